// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: round-robin SPI scan master for ADCx08S102-family ADCs.
// Ports: clk, rst_n (async, active-low), en, ch_en[NUM_CH] -> scan control;
//   dout <- ADC; din, cs_n, sclk -> ADC (all registered, sclk idles high);
//   data, data_ch, data_valid, frame_err, busy -> result side.
// Optional: define ADC_SCAN_FRAME_CHECK_EN to enable the framing check.
module adc_scan_ctrl #(
    parameter int CLK_DIV  = 3,
    parameter int RES_BITS = 10,
    parameter int NUM_CH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                dout,
    output logic                din,
    output logic                cs_n,
    output logic                sclk,
    output logic [RES_BITS-1:0] data,
    output logic [2:0]          data_ch,
    output logic                data_valid,
    output logic                busy,
    output logic                frame_err
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    state_t state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [4:0] hp_q, hp_d;
    logic [2:0] addr_q, addr_d;
    logic [2:0] conv_q, conv_d;
    logic first_q, first_d;
    logic [15:0] sr_q, sr_d;
    logic cs_n_q, cs_n_d;
    logic sclk_q, sclk_d;
    logic din_q, din_d;
    logic dv_q, dv_d;
    logic busy_q, busy_d;
    logic [RES_BITS-1:0] data_q, data_d;
    logic [2:0] data_ch_q, data_ch_d;
    logic tick_last, start, launch;
    logic unused_sr;

    // Lowest enabled index above cur, else wrap to the lowest enabled one.
    function automatic logic [2:0] next_addr(input logic [2:0] cur,
                                             input logic [NUM_CH-1:0] m);
        logic [2:0] lo, hi;
        logic found;
        lo = '0;
        hi = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                lo = 3'(i);
                if (i > int'(cur)) begin
                    hi = 3'(i);
                    found = 1'b1;
                end
            end
        end
        return found ? hi : lo;
    endfunction

    assign tick_last = (tick_q == TICK_LAST);
    assign start     = en && (|ch_en);
    assign launch    = start && ((state_q == IDLE) ||
                       (state_q == QUIET && tick_last && hp_q[0]));

    always_comb begin
        state_d = state_q;
        tick_d  = '0;
        hp_d    = hp_q;
        addr_d  = addr_q;
        conv_d  = conv_q;
        first_d = first_q;
        sr_d    = sr_q;
        unique case (state_q)
            IDLE: begin
                if (launch) state_d = SETUP;
            end
            SETUP: begin
                if (tick_last) begin
                    state_d = SHIFT;
                    hp_d    = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            SHIFT: begin
                // odd half-period index = sclk high; first cycle = rising edge
                if (hp_q[0] && tick_q == '0) sr_d = {sr_q[14:0], dout};
                if (tick_last) begin
                    if (hp_q == 5'd31) begin
                        state_d = QUIET;
                        hp_d    = '0;
                    end else begin
                        hp_d = hp_q + 5'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            QUIET: begin
                if (tick_last) begin
                    if (hp_q[0]) begin
                        if (launch) begin
                            state_d = SETUP;
                        end else begin
                            state_d = IDLE;
                            first_d = 1'b1;
                        end
                    end else begin
                        hp_d = hp_q + 5'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // The converter samples the address one frame ahead of converting it.
        if (launch) begin
            addr_d  = next_addr(addr_q, ch_en);
            conv_d  = first_q ? 3'd0 : addr_q;
            first_d = 1'b0;
        end
    end

    always_comb begin
        cs_n_d    = (state_d == IDLE) || (state_d == QUIET);
        sclk_d    = (state_d == SHIFT) ? hp_d[0] : 1'b1;
        din_d     = 1'b0;
        if (state_d == SHIFT) begin
            case (hp_d[4:1])
                4'd2:    din_d = addr_d[2];
                4'd3:    din_d = addr_d[1];
                4'd4:    din_d = addr_d[0];
                default: din_d = 1'b0;
            endcase
        end
        dv_d      = (state_q == SHIFT) && (state_d == QUIET);
        busy_d    = (state_d != IDLE);
        data_d    = dv_d ? sr_d[11 -: RES_BITS] : data_q;
        data_ch_d = dv_d ? conv_q : data_ch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            hp_q      <= '0;
            addr_q    <= '0;
            conv_q    <= '0;
            first_q   <= 1'b1;
            sr_q      <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            data_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            hp_q      <= hp_d;
            addr_q    <= addr_d;
            conv_q    <= conv_d;
            first_q   <= first_d;
            sr_q      <= sr_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
        end
    end

`ifdef ADC_SCAN_FRAME_CHECK_EN
    // Leading 4 bits plus the 12-RES_BITS trailing bits must all be zero.
    localparam logic [15:0] CHK_MASK =
        16'hF000 | 16'((32'd1 << (12 - RES_BITS)) - 32'd1);
    logic err_q, err_d;

    assign err_d = dv_d ? (|(sr_d & CHK_MASK)) : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign unused_sr  = ^{sr_q, sr_d};
    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign din        = din_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;
    assign data       = data_q;
    assign data_ch    = data_ch_q;
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed bench with ADC models and result scoreboards.
// Covers framing, address pipeline, en drop, reset abort, empty mask, 12-bit.
module tb_adc_scan_ctrl;
`ifdef ADC_SCAN_FRAME_CHECK_EN
    localparam logic FC = 1'b1;
`else
    localparam logic FC = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] d;
        logic [2:0]  ch;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [7:0] ch_en = '0;
    logic dout = 1'b0;
    logic din, cs_n, sclk, data_valid, busy, frame_err;
    logic [9:0] data;
    logic [2:0] data_ch;

    logic en12 = 1'b0;
    logic [3:0] ch_en12 = '0;
    logic dout12 = 1'b0;
    logic din12, cs12, sclk12, dv12, busy12, err12;
    logic [11:0] data12;
    logic [2:0] ch12;

    adc_scan_ctrl #(.CLK_DIV(3), .RES_BITS(10), .NUM_CH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .dout(dout),
        .din(din), .cs_n(cs_n), .sclk(sclk), .data(data),
        .data_ch(data_ch), .data_valid(data_valid), .busy(busy),
        .frame_err(frame_err)
    );

    adc_scan_ctrl #(.CLK_DIV(2), .RES_BITS(12), .NUM_CH(4)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .en(en12), .ch_en(ch_en12), .dout(dout12),
        .din(din12), .cs_n(cs12), .sclk(sclk12), .data(data12),
        .data_ch(ch12), .data_valid(dv12), .busy(busy12),
        .frame_err(err12)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_csf = 0, t_csf = 0;
    int n_sr = 0, t_sr = 0, t_sr_prev = 0;
    int t_dv = 0, t_idle = 0;
    exp_t sb[$];
    exp_t sb12[$];
    exp_t e_main, e_12;
    logic [2:0] addr_log[$];

    logic [15:0] m_fixed, m_frame, f12;
    logic m_echo;
    logic [2:0] m_conv = '0, m_next = '0;
    int m_bit = 0, m_re = 0, b12 = 0;

    function automatic exp_t mk(input logic [11:0] d, input logic [2:0] ch,
                                input logic err);
        exp_t e;
        e.d = d;
        e.ch = ch;
        e.err = err;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // ADC model: one-frame address pipeline, data shifted on sclk falling.
    always @(negedge cs_n) if (rst_n) begin
        n_csf++;
        t_csf = cyc;
        m_bit = 0;
        m_re = 0;
        m_frame = m_echo ? {11'd0, m_conv, 2'd0} : m_fixed;
    end

    always @(posedge cs_n) if (rst_n) m_conv = m_next;

    always @(negedge sclk) if (rst_n && !cs_n && m_bit < 16) begin
        dout = m_frame[15 - m_bit];
        m_bit++;
    end

    always @(posedge sclk) if (rst_n && !cs_n) begin
        n_sr++;
        t_sr_prev = t_sr;
        t_sr = cyc;
        m_re++;
        if (m_re >= 3 && m_re <= 5) m_next = {m_next[1:0], din};
        if (m_re == 5) addr_log.push_back(m_next);
    end

    always @(negedge cs12) b12 = 0;

    always @(negedge sclk12) if (rst_n && !cs12 && b12 < 16) begin
        dout12 = f12[15 - b12];
        b12++;
    end

    always @(negedge clk) if (data_valid === 1'b1) begin
        if (sb.size() == 0) begin
            check("unexpected_dv", 32'd1, 32'd0);
        end else begin
            e_main = sb.pop_front();
            check("data", 32'(data), 32'(e_main.d));
            check("data_ch", 32'(data_ch), 32'(e_main.ch));
            check("frame_err", 32'(frame_err), 32'(e_main.err));
        end
    end

    always @(negedge clk) if (dv12 === 1'b1) begin
        if (sb12.size() == 0) begin
            check("unexpected_dv12", 32'd1, 32'd0);
        end else begin
            e_12 = sb12.pop_front();
            check("data12", 32'(data12), 32'(e_12.d));
            check("data_ch12", 32'(ch12), 32'(e_12.ch));
            check("frame_err12", 32'(err12), 32'(e_12.err));
        end
    end

    task automatic wait_csf(input string tag, input int budget);
        int n0;
        int i;
        n0 = n_csf;
        i = 0;
        while (n_csf == n0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(n_csf != n0), 32'd1);
    endtask

    task automatic wait_sr(input string tag, input int n, input int budget);
        int n0;
        int i;
        n0 = n_sr;
        i = 0;
        while (n_sr < n0 + n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(n_sr >= n0 + n), 32'd1);
    endtask

    task automatic wait_dv(input string tag, input int budget);
        int i;
        bit hit;
        i = 0;
        hit = 1'b0;
        while (!hit && i < budget) begin
            @(negedge clk);
            i++;
            hit = (data_valid === 1'b1);
        end
        t_dv = cyc;
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        bit hit;
        i = 0;
        hit = 1'b0;
        while (!hit && i < budget) begin
            @(negedge clk);
            i++;
            hit = (busy === 1'b0);
        end
        t_idle = cyc;
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic chk_reset_vals(input string p);
        check({p, "_cs_n"}, 32'(cs_n), 32'd1);
        check({p, "_sclk"}, 32'(sclk), 32'd1);
        check({p, "_din"}, 32'(din), 32'd0);
        check({p, "_data"}, 32'(data), 32'd0);
        check({p, "_data_ch"}, 32'(data_ch), 32'd0);
        check({p, "_dv"}, 32'(data_valid), 32'd0);
        check({p, "_busy"}, 32'(busy), 32'd0);
        check({p, "_err"}, 32'(frame_err), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        en12 = 1'b0;
        #1;
        m_conv = '0;
        m_next = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, nf, i12;
        bit bad, hit12;
        logic [2:0] a_exp[4];
        a_exp = '{3'd2, 3'd5, 3'd7, 3'd2};
        m_echo = 1'b0;
        m_fixed = 16'h0A94;
        f12 = 16'h1FFF;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        sb.push_back(mk(12'h2A5, 3'd0, 1'b0));
        sb.push_back(mk(12'h2A5, 3'd0, 1'b0));
        ch_en = 8'h01;
        en = 1'b1;
        wait_csf("t1_start", 20);
        t0 = t_csf;
        wait_sr("t1_sclk", 2, 200);
        check("sclk_period", 32'(t_sr - t_sr_prev), 32'd6);
        wait_csf("t1_next", 200);
        check("frame_period", 32'(t_csf - t0), 32'd105);
        wait_sr("t1_mid", 3, 100);
        en = 1'b0;
        nf = n_csf;
        wait_dv("t1_dv", 200);
        wait_idle("t1_idle", 50);
        check("busy_tail", 32'(t_idle - t_dv), 32'd6);
        repeat (200) @(negedge clk);
        check("no_restart", 32'(n_csf), 32'(nf));

        do_reset();
        m_echo = 1'b1;
        addr_log.delete();
        sb.push_back(mk(12'd0, 3'd0, 1'b0));
        sb.push_back(mk(12'd2, 3'd2, 1'b0));
        sb.push_back(mk(12'd5, 3'd5, 1'b0));
        sb.push_back(mk(12'd7, 3'd7, 1'b0));
        sb.push_back(mk(12'd2, 3'd2, 1'b0));
        ch_en = 8'b1010_0100;
        en = 1'b1;
        repeat (5) wait_dv("t2_dv", 200);
        en = 1'b0;
        wait_idle("t2_idle", 50);
        check("addr_cnt", 32'(addr_log.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k < addr_log.size())
                check("din_addr", 32'(addr_log[k]), 32'(a_exp[k]));
        end

        ch_en = 8'h06;
        en = 1'b1;
        wait_csf("t4_start", 20);
        wait_sr("t4_mid", 3, 100);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        m_conv = '0;
        m_next = '0;
        repeat (4) @(negedge clk);
        sb.push_back(mk(12'd0, 3'd0, 1'b0));
        rst_n = 1'b1;
        wait_dv("t4_dv", 200);
        en = 1'b0;
        wait_idle("t4_idle", 50);

        m_echo = 1'b0;
        m_fixed = 16'h8A95;
        ch_en = 8'h00;
        en = 1'b1;
        nf = n_csf;
        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("zero_mask_idle", 32'(bad), 32'd0);
        check("zero_mask_nocs", 32'(n_csf), 32'(nf));
        addr_log.delete();
        sb.push_back(mk(12'h2A5, 3'd0, FC));
        ch_en = 8'h10;
        wait_csf("t6_start", 20);
        en = 1'b0;
        wait_dv("t6_dv", 200);
        wait_idle("t6_idle", 50);
        check("t6_addr_n", 32'(addr_log.size()), 32'd1);
        if (addr_log.size() > 0)
            check("t6_addr", 32'(addr_log[0]), 32'd4);

        sb12.push_back(mk(12'hFFF, 3'd0, FC));
        ch_en12 = 4'b0001;
        en12 = 1'b1;
        i12 = 0;
        hit12 = 1'b0;
        while (!hit12 && i12 < 200) begin
            @(negedge clk);
            i12++;
            hit12 = (dv12 === 1'b1);
        end
        check("t12_dv", 32'(hit12), 32'd1);
        t0 = cyc;
        en12 = 1'b0;
        i12 = 0;
        hit12 = 1'b0;
        while (!hit12 && i12 < 50) begin
            @(negedge clk);
            i12++;
            hit12 = (busy12 === 1'b0);
        end
        check("t12_idle", 32'(hit12), 32'd1);
        check("t12_busy_tail", 32'(cyc - t0), 32'd4);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("sb12_empty", 32'(sb12.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
